nibble_add_sequencer: RTL

- Multi-cycle controller that performs a wide add on a single shared 4-bit ripple-carry adder, one nibble per cycle, least-significant nibble first.
- Latches the wide operands on a start handshake and drives the external adder's A/B/cin for each nibble.
- Captures the adder's sum and carry-out every cycle, chains the carry, and reports the registered result with a one-cycle done pulse.
- Sits between the switch/register front end and the existing 4-bit adder instance, so wide arithmetic needs no extra adder hardware.

---
 rtl/nibble_add_sequencer_if.sv | 33 +++
 rtl/nibble_add_sequencer.sv | 111 +++++++++++
 2 files changed

// File: rtl/nibble_add_sequencer_if.sv
// Request/result bus of the nibble add sequencer plus its link to the shared 4-bit adder.
// Latency: none, wiring only. Backpressure: none; start is honoured only while busy is low.
// slave = the sequencer, master = front end together with the shared adder.
interface nibble_add_sequencer_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         op;
  logic [3:0]   adder_a;
  logic [3:0]   adder_b;
  logic         adder_cin;
  logic [3:0]   adder_s;
  logic         adder_cout;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  modport slave (
    input  start, a, b, cin, op, adder_s, adder_cout,
    output adder_a, adder_b, adder_cin, busy, done, sum, cout
  );

  modport master (
    output start, a, b, cin, op, adder_s, adder_cout,
    input  adder_a, adder_b, adder_cin, busy, done, sum, cout
  );
endinterface

// File: rtl/nibble_add_sequencer.sv
// Wide add (subtract with NIBBLE_SEQ_SUB_EN) on one shared 4-bit adder, LS nibble first.
// Latency: done pulses NIBBLES cycles after the accepting edge; one operation every NIBBLES+1 cycles.
// Backpressure: start is taken only in IDLE; a start while busy is dropped, never queued.
module nibble_add_sequencer #(
  parameter int NIBBLES = 4
) (
  input  logic                   clock,
  input  logic                   resetn,
  nibble_add_sequencer_if.slave  bus
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES);
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic          cin_reg;
  logic          op_reg;
  logic          carry;
  logic [W-1:0]  sum_q;
  logic          cout_q;
  logic          busy_q;
  logic          done_q;

  logic [3:0]    nib_a;
  logic [3:0]    nib_b;
  logic          nib_cin;
  logic          sub_sel;

`ifdef NIBBLE_SEQ_SUB_EN
  assign sub_sel = op_reg;
`else
  // Subtract path is compiled out; op is latched but has no effect.
  logic unused_op;
  assign sub_sel   = 1'b0;
  assign unused_op = &{1'b0, op_reg};
`endif

  always_comb begin
    nib_a   = 4'd0;
    nib_b   = 4'd0;
    nib_cin = 1'b0;
    if (state == RUN) begin
      nib_a = a_reg[4*int'(idx) +: 4];
`ifdef NIBBLE_SEQ_SUB_EN
      nib_b = sub_sel ? ~b_reg[4*int'(idx) +: 4] : b_reg[4*int'(idx) +: 4];
`else
      nib_b = b_reg[4*int'(idx) +: 4];
`endif
      // Subtract forces the +1 of two's complement into nibble 0.
      if (idx == '0) nib_cin = sub_sel ? 1'b1 : cin_reg;
      else           nib_cin = carry;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state   <= IDLE;
      idx     <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      cin_reg <= 1'b0;
      op_reg  <= 1'b0;
      carry   <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_reg   <= bus.a;
            b_reg   <= bus.b;
            cin_reg <= bus.cin;
            op_reg  <= bus.op;
            idx     <= '0;
            busy_q  <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          sum_q[4*int'(idx) +: 4] <= bus.adder_s;
          carry                   <= bus.adder_cout;
          if (idx == LAST) begin
            cout_q <= bus.adder_cout;
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.adder_a   = nib_a;
  assign bus.adder_b   = nib_b;
  assign bus.adder_cin = nib_cin;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
endmodule
